fifo_wr_arbiter: RTL and testbench

- Round-robin, packet-granular arbiter that shares the single write port of the 8-bit byte FIFO (512 deep) among NUM_REQ requesters.
- Sits in the write-clock domain, directly in front of the FIFO wr_en/wr_data/full/almost_full pins.
- Holds a grant for a whole packet.
- Starts a packet only while the FIFO is not almost full.
- Force-terminates any packet that exceeds MAX_PKT_LEN bytes.

---
 rtl/fifo_wr_arbiter.sv | 130 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Packet-granular round-robin arbiter for a shared FIFO write port.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_PKT_LEN = 64,
  parameter int CNT_WIDTH   = 16,
  localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [IDX_W-1:0]              grant_id,
  output logic                          busy,
  output logic                          pkt_overflow,
  output logic [CNT_WIDTH-1:0]          pkt_cnt
);

  localparam int BEAT_W = $clog2(MAX_PKT_LEN);

  localparam logic [0:0]        c_st_idle   = 1'b0;
  localparam logic [0:0]        c_st_xfer   = 1'b1;
  localparam logic [BEAT_W-1:0] c_beat_last = BEAT_W'(MAX_PKT_LEN - 1);

  logic [0:0]           r_state;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [IDX_W-1:0]     r_grant_id;
  logic [BEAT_W-1:0]    r_beat_cnt;
  logic [CNT_WIDTH-1:0] r_pkt_cnt;
  logic                 r_pkt_overflow;

  logic                 w_found;
  logic [IDX_W-1:0]     w_pick;
  logic                 w_xfer;
  logic                 w_gnt_valid;
  logic                 w_gnt_last;
  logic                 w_accept;
  logic                 w_at_limit;
  logic                 w_pkt_end;
  logic                 w_force_end;

  // Search starts one past the last served requester, so it ends up lowest priority.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_pick  = '0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_pick  = IDX_W'(idx);
      end
    end
  end

  assign w_xfer      = (r_state == c_st_xfer);
  assign w_gnt_valid = req_valid[r_grant_id];
  assign w_gnt_last  = req_last[r_grant_id];
  assign w_accept    = w_xfer & w_gnt_valid & ~fifo_full;
  assign w_at_limit  = (r_beat_cnt == c_beat_last);
  assign w_pkt_end   = w_accept & (w_gnt_last | w_at_limit);
  assign w_force_end = w_accept & ~w_gnt_last & w_at_limit;

  always_comb begin
    req_ready = '0;
    if (w_xfer) begin
      req_ready[r_grant_id] = ~fifo_full;
    end
  end

  assign fifo_wr_en   = w_accept;
  assign fifo_wr_data = req_data[int'(r_grant_id)*DATA_WIDTH +: DATA_WIDTH];
  assign grant_id     = r_grant_id;
  assign busy         = w_xfer;
  assign pkt_overflow = r_pkt_overflow;
  assign pkt_cnt      = r_pkt_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= c_st_idle;
      r_rr_ptr       <= IDX_W'(NUM_REQ - 1);
      r_grant_id     <= '0;
      r_beat_cnt     <= '0;
      r_pkt_cnt      <= '0;
      r_pkt_overflow <= 1'b0;
    end else begin
      r_pkt_overflow <= w_force_end;
      case (r_state)
        c_st_idle: begin
          // almost_full only gates the start of a packet, never one in flight.
          if (w_found && !fifo_almost_full) begin
            r_grant_id <= w_pick;
            r_beat_cnt <= '0;
            r_state    <= c_st_xfer;
          end
        end
        c_st_xfer: begin
          if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
          end
          if (w_pkt_end) begin
            r_state   <= c_st_idle;
            r_rr_ptr  <= r_grant_id;
            r_pkt_cnt <= r_pkt_cnt + CNT_WIDTH'(1);
          end
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Directed self-checking bench for fifo_wr_arbiter (4 req, max 4 beats).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int DATA_WIDTH  = 8;
  localparam int MAX_PKT_LEN = 4;
  localparam int CNT_WIDTH   = 16;

  logic                          clk;
  logic                          rst_n;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_almost_full;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic [1:0]                    grant_id;
  logic                          busy;
  logic                          pkt_overflow;
  logic [CNT_WIDTH-1:0]          pkt_cnt;

  int checks = 0;
  int errors = 0;

  // Per-requester beat sources: {last, data}
  logic [8:0] src [NUM_REQ][32];
  int         wp  [NUM_REQ];
  int         rp  [NUM_REQ];

  logic [7:0] log_data [256];
  int         log_gnt  [256];
  int         nlog;

  fifo_wr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_PKT_LEN(MAX_PKT_LEN),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_last        (req_last),
    .req_ready       (req_ready),
    .fifo_full       (fifo_full),
    .fifo_almost_full(fifo_almost_full),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_wr_data    (fifo_wr_data),
    .grant_id        (grant_id),
    .busy            (busy),
    .pkt_overflow    (pkt_overflow),
    .pkt_cnt         (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rp[i] < wp[i]) begin
        req_valid[i]          = 1'b1;
        req_data[i*8 +: 8]    = src[i][rp[i]][7:0];
        req_last[i]           = src[i][rp[i]][8];
      end else begin
        req_valid[i]          = 1'b0;
        req_data[i*8 +: 8]    = 8'h00;
        req_last[i]           = 1'b0;
      end
    end
    #1;
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic last);
    src[r][wp[r]] = {last, d};
    wp[r] = wp[r] + 1;
  endtask

  // Records the current cycle, then advances one clock and re-drives sources.
  task automatic step();
    logic [NUM_REQ-1:0] popm;
    if (fifo_wr_en) begin
      checks++;
      if (fifo_full) begin
        errors++;
        $display("FAIL wr_en_while_full: wr_en=%b full=%b required wr_en=0", fifo_wr_en, fifo_full);
      end
      if (nlog < 256) begin
        log_data[nlog] = fifo_wr_data;
        log_gnt[nlog]  = int'(grant_id);
        nlog++;
      end
    end
    popm = req_ready & req_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (popm[i]) rp[i] = rp[i] + 1;
    end
    drive();
  endtask

  task automatic apply_reset();
    rst_n            = 1'b0;
    fifo_full        = 1'b0;
    fifo_almost_full = 1'b0;
    nlog             = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      wp[i] = 0;
      rp[i] = 0;
    end
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    fifo_full = 1'b0;
    fifo_almost_full = 1'b0;
    nlog = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      wp[i] = 0;
      rp[i] = 0;
    end
    drive();
    #1;
    checks++;
    if ({busy, pkt_overflow, fifo_wr_en, req_ready, grant_id, pkt_cnt} !== 25'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b ovf=%b wr_en=%b ready=%b gid=%0d cnt=%0d required all 0",
               busy, pkt_overflow, fifo_wr_en, req_ready, grant_id, pkt_cnt);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive();
  endtask

  task automatic test_single();
    apply_reset();
    push(2, 8'hA1, 1'b0);
    push(2, 8'hA2, 1'b0);
    push(2, 8'hA3, 1'b1);
    drive();
    checks++;
    if (busy !== 1'b0 || fifo_wr_en !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL single_arb_cycle: busy=%b wr_en=%b ready=%b required 0,0,0000", busy, fifo_wr_en, req_ready);
    end
    step();
    checks++;
    if (grant_id !== 2'd2 || busy !== 1'b1 || req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_grant: gid=%0d busy=%b ready=%b required 2,1,0100", grant_id, busy, req_ready);
    end
    for (int c = 0; c < 3; c++) step();
    checks++;
    if (nlog !== 3 || log_data[0] !== 8'hA1 || log_data[1] !== 8'hA2 || log_data[2] !== 8'hA3) begin
      errors++;
      $display("FAIL single_data: n=%0d d=%h %h %h required 3 a1 a2 a3", nlog, log_data[0], log_data[1], log_data[2]);
    end
    checks++;
    if (pkt_cnt !== 16'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_end: cnt=%0d busy=%b required 1,0", pkt_cnt, busy);
    end
  endtask

  task automatic test_round_robin();
    int p;
    int r;
    logic [7:0] exp_d;
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int s = 0; s < 4; s++) begin
        push(i, {i[3:0], s[3:0]}, s[0]);
      end
    end
    drive();
    for (int k = 1; k <= 8; k++) begin
      step();
      step();
      step();
      checks++;
      if (pkt_cnt !== CNT_WIDTH'(k) || busy !== 1'b0) begin
        errors++;
        $display("FAIL rr_period_%0d: cnt=%0d busy=%b required %0d,0", k, pkt_cnt, busy, k);
      end
    end
    checks++;
    if (nlog !== 16) begin
      errors++;
      $display("FAIL rr_count: n=%0d required 16", nlog);
    end
    for (int j = 0; j < 16; j++) begin
      p = j / 2;
      r = p % 4;
      exp_d = {r[3:0], 4'((p / 4) * 2 + (j % 2))};
      checks++;
      if (log_data[j] !== exp_d || log_gnt[j] !== r) begin
        errors++;
        $display("FAIL rr_beat_%0d: data=%h gid=%0d required %h,%0d", j, log_data[j], log_gnt[j], exp_d, r);
      end
    end
  endtask

  task automatic test_fifo_full();
    apply_reset();
    push(1, 8'hB0, 1'b0);
    push(1, 8'hB1, 1'b0);
    push(1, 8'hB2, 1'b0);
    push(1, 8'hB3, 1'b1);
    drive();
    step();
    step();
    fifo_full = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (req_ready[1] !== 1'b0 || fifo_wr_en !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL full_stall_%0d: ready1=%b wr_en=%b busy=%b required 0,0,1", c, req_ready[1], fifo_wr_en, busy);
      end
      step();
    end
    fifo_full = 1'b0;
    #1;
    checks++;
    if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'hB1) begin
      errors++;
      $display("FAIL full_resume: wr_en=%b data=%h required 1,b1", fifo_wr_en, fifo_wr_data);
    end
    for (int c = 0; c < 3; c++) step();
    checks++;
    if (nlog !== 4 || log_data[0] !== 8'hB0 || log_data[1] !== 8'hB1 ||
        log_data[2] !== 8'hB2 || log_data[3] !== 8'hB3 || pkt_cnt !== 16'd1) begin
      errors++;
      $display("FAIL full_data: n=%0d d=%h %h %h %h cnt=%0d required 4 b0 b1 b2 b3 cnt 1",
               nlog, log_data[0], log_data[1], log_data[2], log_data[3], pkt_cnt);
    end
  endtask

  task automatic test_almost_full();
    apply_reset();
    fifo_almost_full = 1'b1;
    push(0, 8'hC1, 1'b0);
    push(0, 8'hC2, 1'b0);
    push(0, 8'hC3, 1'b1);
    drive();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (busy !== 1'b0 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL af_hold_%0d: busy=%b ready=%b required 0,0000", c, busy, req_ready);
      end
      step();
    end
    fifo_almost_full = 1'b0;
    #1;
    step();
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL af_grant: busy=%b gid=%0d required 1,0", busy, grant_id);
    end
    fifo_almost_full = 1'b1;
    #1;
    checks++;
    if (fifo_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL af_in_xfer: wr_en=%b required 1", fifo_wr_en);
    end
    for (int c = 0; c < 3; c++) step();
    checks++;
    if (nlog !== 3 || log_data[2] !== 8'hC3 || pkt_cnt !== 16'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL af_complete: n=%0d last=%h cnt=%0d busy=%b required 3,c3,1,0", nlog, log_data[2], pkt_cnt, busy);
    end
    fifo_almost_full = 1'b0;
    #1;
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int b = 1; b <= 6; b++) begin
      push(3, 8'hD0 + 8'(b), (b == 6));
    end
    drive();
    for (int c = 0; c < 4; c++) step();
    checks++;
    if (pkt_overflow !== 1'b0 || fifo_wr_data !== 8'hD4) begin
      errors++;
      $display("FAIL ovf_beat4: ovf=%b data=%h required 0,d4", pkt_overflow, fifo_wr_data);
    end
    step();
    checks++;
    if (pkt_overflow !== 1'b1 || pkt_cnt !== 16'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ovf_pulse: ovf=%b cnt=%0d busy=%b required 1,1,0", pkt_overflow, pkt_cnt, busy);
    end
    step();
    checks++;
    if (pkt_overflow !== 1'b0 || busy !== 1'b1 || grant_id !== 2'd3) begin
      errors++;
      $display("FAIL ovf_regrant: ovf=%b busy=%b gid=%0d required 0,1,3", pkt_overflow, busy, grant_id);
    end
    step();
    step();
    checks++;
    if (pkt_cnt !== 16'd2 || nlog !== 6 || log_data[4] !== 8'hD5 || log_data[5] !== 8'hD6 || pkt_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_second: cnt=%0d n=%0d d=%h %h ovf=%b required 2,6,d5,d6,0",
               pkt_cnt, nlog, log_data[4], log_data[5], pkt_overflow);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int b = 1; b <= 5; b++) begin
      push(2, 8'hE0 + 8'(b), (b == 5));
    end
    drive();
    step();
    push(0, 8'hF0, 1'b1);
    drive();
    step();
    checks++;
    if (busy !== 1'b1 || fifo_wr_data !== 8'hE2) begin
      errors++;
      $display("FAIL rmid_pre: busy=%b data=%h required 1,e2", busy, fifo_wr_data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, pkt_overflow, fifo_wr_en, req_ready, grant_id, pkt_cnt} !== 25'd0) begin
      errors++;
      $display("FAIL rmid_async: busy=%b ovf=%b wr_en=%b ready=%b gid=%0d cnt=%0d required all 0",
               busy, pkt_overflow, fifo_wr_en, req_ready, grant_id, pkt_cnt);
    end
    step();
    rst_n = 1'b1;
    #1;
    step();
    checks++;
    if (grant_id !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rmid_regrant: gid=%0d busy=%b required 0,1", grant_id, busy);
    end
  endtask

  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_fifo_full();
    test_almost_full();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
